// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state codes and lamp encodings for the crossing controller.
package traffic_pkg;

    // Code 7 is unused; the controller forces it back to ALLRED2.
    typedef enum logic [2:0] {
        L_GREEN  = 3'd0,
        L_YELLOW = 3'd1,
        ALLRED1  = 3'd2,
        C_GREEN  = 3'd3,
        C_YELLOW = 3'd4,
        ALLRED2  = 3'd5,
        FLASH    = 3'd6,
        ST_ILL   = 3'd7
    } state_t;

    // Lamp encoding {G,Y,R}
    localparam logic [2:0] LAMP_G   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_R   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

endpackage

// File: rtl/phase_timer.sv
// phase_timer: elapsed-cycle counter for the current controller phase.
//   i_clk, i_rst_n : clock, async active-low reset (count -> 0)
//   i_clr          : restart from 0 on the next edge (state change)
//   i_wrap         : restart from 0 when the terminal count is reached
//   i_term         : terminal count value
//   o_cnt          : current count
//   o_term         : o_cnt equals i_term
module phase_timer #(
    parameter int TW = 7
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_wrap,
    input  logic [TW-1:0] i_term,
    output logic [TW-1:0] o_cnt,
    output logic          o_term
);

    logic [TW-1:0] r_cnt;

    assign o_cnt  = r_cnt;
    assign o_term = (r_cnt == i_term);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_clr || (i_wrap && o_term))
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/traffic_ctrl_param.sv
// traffic_ctrl_param: two-road traffic-light controller with configurable
// phase durations, all-red clearance, latched pedestrian request that can
// cut the Lengthway green short, and a night flashing-yellow mode.
//   CLK       : clock, rising edge
//   Rd_       : async active-low reset (enters ALLRED2, Timer=0)
//   Night     : night-mode request, sampled only at the end of all-red phases
//   PedReq    : pedestrian request (pulse or level)
//   Lengthway : lamps {G,Y,R} for the Lengthway road
//   Crosswise : lamps {G,Y,R} for the Crosswise road
//   Timer     : cycles elapsed in the current phase
//   State     : current state code
//   PedAck    : one-cycle pulse on the first C_GREEN cycle when a request is served
module traffic_ctrl_param
    import traffic_pkg::*;
#(
    parameter int TW          = 7,
    parameter int T_GREEN_L   = 60,
    parameter int T_GREEN_C   = 30,
    parameter int T_YELLOW    = 5,
    parameter int T_ALLRED    = 2,
    parameter int T_MIN_GREEN = 15,
    parameter int FLASH_HALF  = 4
) (
    input  logic          CLK,
    input  logic          Rd_,
    input  logic          Night,
    input  logic          PedReq,
    output logic [2:0]    Lengthway,
    output logic [2:0]    Crosswise,
    output logic [TW-1:0] Timer,
    output logic [2:0]    State,
    output logic          PedAck
);

    localparam logic [TW-1:0] TC_GL    = TW'(T_GREEN_L - 1);
    localparam logic [TW-1:0] TC_GC    = TW'(T_GREEN_C - 1);
    localparam logic [TW-1:0] TC_Y     = TW'(T_YELLOW - 1);
    localparam logic [TW-1:0] TC_AR    = TW'(T_ALLRED - 1);
    localparam logic [TW-1:0] TC_MIN   = TW'(T_MIN_GREEN - 1);
    localparam logic [TW-1:0] TC_FLASH = TW'(2 * FLASH_HALF - 1);
    localparam logic [TW-1:0] FH       = TW'(FLASH_HALF);

    state_t        r_state;
    state_t        w_next;
    logic          r_ped;     // latched pedestrian request
    logic          r_served;  // a request was pending when C_GREEN was entered
    logic [TW-1:0] w_term_at;
    logic          w_term;
    logic          w_clr;
    logic          w_flash;
    logic [2:0]    w_flash_lamp;

    // Every transition changes the state code, so a state change is exactly
    // the point where the phase timer must restart.
    assign w_clr   = (w_next != r_state);
    assign w_flash = (r_state == FLASH);

    always_comb begin
        w_term_at = TC_AR;
        case (r_state)
            L_GREEN:  w_term_at = TC_GL;
            L_YELLOW: w_term_at = TC_Y;
            C_GREEN:  w_term_at = TC_GC;
            C_YELLOW: w_term_at = TC_Y;
            FLASH:    w_term_at = TC_FLASH;
            default:  w_term_at = TC_AR;
        endcase
    end

    phase_timer #(.TW(TW)) u_timer (
        .i_clk   (CLK),
        .i_rst_n (Rd_),
        .i_clr   (w_clr),
        .i_wrap  (w_flash),
        .i_term  (w_term_at),
        .o_cnt   (Timer),
        .o_term  (w_term)
    );

    // State register
    always_ff @(posedge CLK or negedge Rd_) begin
        if (!Rd_)
            r_state <= ALLRED2;
        else
            r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            L_GREEN:  if (w_term || ((r_ped || PedReq) && Timer >= TC_MIN))
                          w_next = L_YELLOW;
            L_YELLOW: if (w_term) w_next = ALLRED1;
            ALLRED1:  if (w_term) w_next = Night ? FLASH : C_GREEN;
            C_GREEN:  if (w_term) w_next = C_YELLOW;
            C_YELLOW: if (w_term) w_next = ALLRED2;
            ALLRED2:  if (w_term) w_next = Night ? FLASH : L_GREEN;
            FLASH:    if (!Night) w_next = ALLRED2;
            default:  w_next = ALLRED2;
        endcase
    end

    // Pedestrian latch: entry into C_GREEN/FLASH wins over a same-cycle
    // request, which is then treated as served by that entry.
    always_ff @(posedge CLK or negedge Rd_) begin
        if (!Rd_) begin
            r_ped    <= 1'b0;
            r_served <= 1'b0;
        end else begin
            if (w_clr && (w_next == C_GREEN || w_next == FLASH))
                r_ped <= 1'b0;
            else if (PedReq && r_state != C_GREEN && r_state != FLASH)
                r_ped <= 1'b1;
            if (w_clr && w_next == C_GREEN)
                r_served <= r_ped | PedReq;
        end
    end

    // Output decode from registered state only
    assign w_flash_lamp = (Timer < FH) ? LAMP_Y : LAMP_OFF;

    always_comb begin
        Lengthway = LAMP_R;
        Crosswise = LAMP_R;
        case (r_state)
            L_GREEN:  Lengthway = LAMP_G;
            L_YELLOW: Lengthway = LAMP_Y;
            C_GREEN:  Crosswise = LAMP_G;
            C_YELLOW: Crosswise = LAMP_Y;
            FLASH: begin
                Lengthway = w_flash_lamp;
                Crosswise = w_flash_lamp;
            end
            default: ;
        endcase
    end

    assign State  = r_state;
    assign PedAck = (r_state == C_GREEN) && (Timer == '0) && r_served;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
module tb_traffic_ctrl_param;

    typedef struct {
        int st;
        int tm;
        bit ped;
        bit srv;
    } mdl_t;

    typedef struct {
        int st;
        int tm;
        int l;
        int c;
        int ack;
    } exp_t;

    logic       CLK = 0;
    logic       Rd_ = 0;
    logic       Night = 0;
    logic       PedReq = 0;
    logic [2:0] Lengthway, Crosswise, State;
    logic [6:0] Timer;
    logic       PedAck;

    logic       rstb = 0;
    logic       pedb = 0;
    logic       nightb = 0;
    logic [2:0] Lb, Cb, Sb;
    logic [3:0] Tb;
    logic       Ab;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int lastb = -1;

    mdl_t ma, mb;
    exp_t qa[$];
    exp_t qb[$];

    always #5 CLK = ~CLK;

    traffic_ctrl_param dut_a (
        .CLK(CLK), .Rd_(Rd_), .Night(Night), .PedReq(PedReq),
        .Lengthway(Lengthway), .Crosswise(Crosswise), .Timer(Timer),
        .State(State), .PedAck(PedAck)
    );

    traffic_ctrl_param #(
        .TW(4), .T_GREEN_L(8), .T_GREEN_C(4), .T_YELLOW(1),
        .T_ALLRED(1), .T_MIN_GREEN(8), .FLASH_HALF(4)
    ) dut_b (
        .CLK(CLK), .Rd_(rstb), .Night(nightb), .PedReq(pedb),
        .Lengthway(Lb), .Crosswise(Cb), .Timer(Tb),
        .State(Sb), .PedAck(Ab)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic mdl_t mreset();
        mdl_t m;
        m.st = 5; m.tm = 0; m.ped = 0; m.srv = 0;
        return m;
    endfunction

    // Reference behaviour of one clock edge, written from the phase table.
    function automatic mdl_t mstep(mdl_t m, bit nt, bit pr, int gl, int gc,
                                   int y, int ar, int mg, int fh);
        mdl_t r;
        int   ns;
        r  = m;
        ns = m.st;
        case (m.st)
            0: if (m.tm == gl - 1 || ((m.ped || pr) && m.tm >= mg - 1)) ns = 1;
            1: if (m.tm == y - 1)  ns = 2;
            2: if (m.tm == ar - 1) ns = nt ? 6 : 3;
            3: if (m.tm == gc - 1) ns = 4;
            4: if (m.tm == y - 1)  ns = 5;
            5: if (m.tm == ar - 1) ns = nt ? 6 : 0;
            6: if (!nt) ns = 5;
            default: ns = 5;
        endcase
        if (ns != m.st)       r.tm = 0;
        else if (m.st == 6)   r.tm = (m.tm == 2 * fh - 1) ? 0 : m.tm + 1;
        else                  r.tm = m.tm + 1;
        if (ns != m.st && (ns == 3 || ns == 6)) r.ped = 0;
        else if (pr && m.st != 3 && m.st != 6) r.ped = 1;
        if (ns == 3 && m.st != 3) r.srv = m.ped | pr;
        r.st = ns;
        return r;
    endfunction

    function automatic exp_t mdec(mdl_t m, int fh);
        exp_t e;
        e.st = m.st; e.tm = m.tm; e.l = 1; e.c = 1;
        e.ack = (m.st == 3 && m.tm == 0 && m.srv) ? 1 : 0;
        case (m.st)
            0: e.l = 4;
            1: e.l = 2;
            3: e.c = 4;
            4: e.c = 2;
            6: begin e.l = (m.tm < fh) ? 2 : 0; e.c = e.l; end
            default: ;
        endcase
        return e;
    endfunction

    // Drive one clock: predict, push, wait for the edge, pop and compare.
    task automatic step();
        exp_t ea, eb;
        ma = Rd_ ? mstep(ma, Night, PedReq, 60, 30, 5, 2, 15, 4) : mreset();
        mb = mstep(mb, nightb, pedb, 8, 4, 1, 1, 8, 4);
        qa.push_back(mdec(ma, 4));
        qb.push_back(mdec(mb, 4));
        @(posedge CLK); #1;
        cyc++;
        ea = qa.pop_front();
        chk("A_state", 32'(State), ea.st);
        chk("A_timer", 32'(Timer), ea.tm);
        chk("A_lamp_L", 32'(Lengthway), ea.l);
        chk("A_lamp_C", 32'(Crosswise), ea.c);
        chk("A_pedack", 32'(PedAck), ea.ack);
        eb = qb.pop_front();
        chk("B_state", 32'(Sb), eb.st);
        chk("B_timer", 32'(Tb), eb.tm);
        chk("B_lamp_L", 32'(Lb), eb.l);
        chk("B_lamp_C", 32'(Cb), eb.c);
        chk("B_pedack", 32'(Ab), eb.ack);
        if (Sb == 3'd0 && Tb == 4'd0) begin
            if (lastb >= 0) chk("B_period", cyc - lastb, 16);
            lastb = cyc;
        end
        // Request in B's first L_GREEN cycle must never shorten its green.
        pedb = (mb.st == 0 && mb.tm == 0);
    endtask

    task automatic wait_st(input int st, input int tm, input int budget);
        int n = 0;
        while (!(ma.st == st && ma.tm == tm) && n < budget) begin
            step();
            n++;
        end
        chk("wait_reach", ma.st * 256 + ma.tm, st * 256 + tm);
    endtask

    initial begin
        int peak[8];
        int acks;

        // Reset state
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("rst_state", 32'(State), 5);
        chk("rst_timer", 32'(Timer), 0);
        chk("rst_lamp_L", 32'(Lengthway), 1);
        chk("rst_lamp_C", 32'(Crosswise), 1);
        chk("rst_pedack", 32'(PedAck), 0);
        ma = mreset();
        mb = mreset();
        Rd_ = 1;
        rstb = 1;

        // 1: free-running default cycle
        wait_st(0, 0, 10);
        foreach (peak[i]) peak[i] = -1;
        acks = 0;
        for (int i = 0; i < 104; i++) begin
            if (int'(Timer) > peak[State]) peak[State] = int'(Timer);
            acks += int'(PedAck);
            step();
        end
        chk("period_A", {29'd0, State} * 256 + 32'(Timer), 0);
        chk("peak_LG", peak[0], 59);
        chk("peak_LY", peak[1], 4);
        chk("peak_AR1", peak[2], 1);
        chk("peak_CG", peak[3], 29);
        chk("peak_CY", peak[4], 4);
        chk("peak_AR2", peak[5], 1);
        chk("no_ack", acks, 0);

        // 2: pulse at L_GREEN Timer=3
        PedReq = 1;
        wait_st(0, 3, 10);
        PedReq = 0;
        wait_st(0, 3, 10);
        PedReq = 1;
        step();
        PedReq = 0;
        acks = 0;
        for (int i = 0; i < 104; i++) begin
            step();
            acks += int'(PedAck);
        end
        chk("ack_count", acks, 1);

        // 3: late request, then held through C_GREEN
        wait_st(0, 40, 200);
        PedReq = 1;
        step();
        chk("late_cut", 32'(State), 1);
        wait_st(4, 1, 100);
        PedReq = 0;
        for (int i = 0; i < 130; i++) step();

        // 4: night mode
        wait_st(3, 10, 300);
        Night = 1;
        for (int i = 0; i < 60; i++) step();
        chk("in_flash", 32'(State), 6);
        Night = 0;
        for (int i = 0; i < 10; i++) step();

        // 5: async reset mid-phase
        wait_st(1, 2, 300);
        #2;
        Rd_ = 0;
        #1;
        chk("arst_state", 32'(State), 5);
        chk("arst_timer", 32'(Timer), 0);
        chk("arst_lamp_L", 32'(Lengthway), 1);
        chk("arst_lamp_C", 32'(Crosswise), 1);
        ma = mreset();
        step();
        Rd_ = 1;
        for (int i = 0; i < 120; i++) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/traffic_ctrl_param.md
Name: traffic_ctrl_param

Overview:
Parametrised two-road traffic-light controller, the next generation of the fixed 60/5/30/5 crossing controller. It adds configurable phase durations, an all-red clearance interval between conflicting greens, and a latched pedestrian request that shortens the Lengthway green. It also adds a night mode in which both roads flash yellow. It sits at the top of the crossing design and drives the lamp outputs and the countdown display directly.

Parameters:
TW, 7, width of Timer; must hold max(T_GREEN_L, T_GREEN_C, 2*FLASH_HALF)-1
T_GREEN_L, 60, Lengthway green duration in cycles (>=1)
T_GREEN_C, 30, Crosswise green duration in cycles (>=1)
T_YELLOW, 5, yellow duration in cycles, both roads (>=1)
T_ALLRED, 2, all-red clearance duration in cycles (>=1)
T_MIN_GREEN, 15, minimum Lengthway green before a pedestrian request may cut it (1..T_GREEN_L)
FLASH_HALF, 4, half-period of night flash in cycles (>=1)

Ports:
CLK  in  1  system clock, rising edge
Rd_  in  1  reset, asynchronous, active-low
Night  in  1  night-mode request, level
PedReq  in  1  pedestrian crossing request (Crosswise), pulse or level
Lengthway  out  3  lamps {G,Y,R}: 100 green, 010 yellow, 001 red, 000 dark
Crosswise  out  3  lamps, same encoding
Timer  out  TW  elapsed cycles in current phase, counts up from 0
State  out  3  current state code
PedAck  out  1  one-cycle pulse when a pending pedestrian request is served

Behaviour:
- Reset (Rd_=0, async): State=ALLRED2, Timer=0, ped_pending=0, PedAck=0, Lengthway=001, Crosswise=001. Reset mid-phase aborts the phase immediately.
- States and lamps (L/C):
  - L_GREEN 100/001
  - L_YELLOW 010/001
  - ALLRED1 001/001
  - C_GREEN 001/100
  - C_YELLOW 001/010
  - ALLRED2 001/001
  - FLASH y/y, where y=010 when Timer<FLASH_HALF, else 000
- Lamps and PedAck are decoded from registered State and Timer only (Moore); no input-to-output combinational path.
- Timer: 0 on the first cycle of every state; +1 per cycle otherwise.
- Timer in FLASH: wraps 2*FLASH_HALF-1 -> 0.
- Timer is never held by saturation, because every non-FLASH state exits at its terminal count.
- Transitions, taken on the edge at the end of the cycle where Timer==DUR-1:
  - L_GREEN -> L_YELLOW
  - L_YELLOW -> ALLRED1
  - ALLRED1 -> C_GREEN, or FLASH if Night=1
  - C_GREEN -> C_YELLOW
  - C_YELLOW -> ALLRED2
  - ALLRED2 -> L_GREEN, or FLASH if Night=1
- Night: sampled only at the end of an ALLRED state; Night is ignored in green and yellow phases, so the cycle always completes to a safe all-red.
- FLASH exit: Night=0 seen in any FLASH cycle -> ALLRED2 next cycle (Timer=0), then L_GREEN.
- Pedestrian latch: ped_pending sets on PedReq=1 in any state except C_GREEN and FLASH.
- Pedestrian cleared: ped_pending clears on entry to C_GREEN or FLASH.
- Early cut: in L_GREEN, if (ped_pending|PedReq) and Timer>=T_MIN_GREEN-1, go to L_YELLOW at the end of that cycle. A same-cycle request counts.
- PedAck: 1 during the first cycle of C_GREEN iff ped_pending was 1 on entry; otherwise 0.
- Simultaneous events:
  - Early cut coinciding with the normal terminal count gives a single transition to L_YELLOW.
  - PedReq on the ALLRED1->C_GREEN edge is cleared by the entry (served).
- Conflicting greens are never possible: each green is entered only from an ALLRED state.

Decomposition:
- Package traffic_pkg holds:
  - state codes: L_GREEN=0, L_YELLOW=1, ALLRED1=2, C_GREEN=3, C_YELLOW=4, ALLRED2=5, FLASH=6 (7 is illegal and recovers to ALLRED2)
  - lamp constants: LAMP_G=100, LAMP_Y=010, LAMP_R=001, LAMP_OFF=000
- One sub-module, phase_timer: a TW-bit up-counter with clear-on-state-change, wrap-at input, and terminal flag.

Test Plan:
1. Defaults, Night=0, PedReq=0, release Rd_: ALLRED2 lasts 2 cycles, then L_GREEN 60, L_YELLOW 5, ALLRED1 2, C_GREEN 30, C_YELLOW 5, ALLRED2 2. Period is 104 cycles; Timer peaks at 59/4/1/29/4/1; PedAck stays 0.
2. PedReq 1-cycle pulse at L_GREEN Timer=3: L_YELLOW is entered after Timer=14, so green lasts 15 cycles. PedAck=1 for exactly the first C_GREEN cycle; the following L_GREEN lasts a full 60 cycles.
3. PedReq at L_GREEN Timer=40: L_YELLOW on the next cycle. PedReq held high through C_GREEN: no re-latch during C_GREEN; the request latches again in C_YELLOW and cuts the next L_GREEN at 15 cycles.
4. Night=1 asserted at C_GREEN Timer=10: C_GREEN and C_YELLOW complete, ALLRED2 runs 2 cycles, then FLASH. Both roads show 010 for 4 cycles and 000 for 4 cycles, repeating. Night=0 gives ALLRED2 for 2 cycles, then L_GREEN.
5. Rd_ pulsed low at L_YELLOW Timer=2, asynchronously mid-cycle: outputs go to 001/001, State=ALLRED2, Timer=0 before the next CLK edge; normal sequence resumes after release.
6. Override T_GREEN_L=8, T_GREEN_C=4, T_YELLOW=1, T_ALLRED=1, T_MIN_GREEN=8, TW=4: period is 16 cycles; PedReq at L_GREEN Timer=0 gives no shortening, since green ends after Timer=7.
